// File: rtl/pipe_pkg.sv
// Shared definitions for generic pipeline stage registers: state encoding,
// occupancy width, and per-stage payload widths with their packed no-op values.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } pipe_state_e;

  localparam int OCC_W = 2;

  // Control field codes mirrored from define.v
  localparam logic [1:0] MEM_NO_RW        = 2'b00;
  localparam logic       REG_WEN_NO_W     = 1'b0;
  localparam logic [3:0] ALU_FUNC_ADD     = 4'b0000;
  localparam logic [1:0] WB_VALD_SEL_VALE = 2'b00;
  localparam logic       COMMIT_NONE      = 1'b0;

  localparam int DE_DATA_W = 128;
  localparam int EM_DATA_W = 96;
  localparam int MW_DATA_W = 72;

  localparam logic [DE_DATA_W-1:0] DE_NOP = {{(DE_DATA_W-10){1'b0}}, ALU_FUNC_ADD,
                                             MEM_NO_RW, REG_WEN_NO_W, WB_VALD_SEL_VALE,
                                             COMMIT_NONE};
  localparam logic [EM_DATA_W-1:0] EM_NOP = {{(EM_DATA_W-6){1'b0}}, MEM_NO_RW,
                                             REG_WEN_NO_W, WB_VALD_SEL_VALE, COMMIT_NONE};
  localparam logic [MW_DATA_W-1:0] MW_NOP = {{(MW_DATA_W-4){1'b0}}, REG_WEN_NO_W,
                                             WB_VALD_SEL_VALE, COMMIT_NONE};

  // The state encoding doubles as the entry count
  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
    logic [OCC_W-1:0] occ;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter: increments on inc, sticks at all-ones, cleared only by reset.
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, optional 2-entry skid,
// stall and flush-to-NOP. Define PIPE_STAGE_PERF_EN to add stall/flush perf counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 128,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
  parameter bit                SKID    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_i_valid,
  input  logic [DATA_W-1:0] up_i_data,
  output logic              up_o_ready,
  output logic              dn_o_valid,
  output logic [DATA_W-1:0] dn_o_data,
  input  logic              dn_i_ready,
  input  logic              ctrl_i_stall,
  input  logic              ctrl_i_flush,
  output logic [OCC_W-1:0]  stage_o_occ
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       perf_o_stall_cnt,
  output logic [15:0]       perf_o_flush_cnt
`endif
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q;
  logic              up_fire, dn_fire;

  assign dn_o_valid  = (state_q != ST_EMPTY);
  assign dn_o_data   = main_q;
  assign stage_o_occ = occ_of(state_q);
  assign up_fire     = up_i_valid & up_o_ready;
  assign dn_fire     = dn_o_valid & dn_i_ready & ~ctrl_i_stall;

  // main_q always holds NOP_VAL when empty, so the output needs no valid gating
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (ctrl_i_flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_fire) begin
            main_d  = up_i_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (up_fire && dn_fire) begin
            main_d = up_i_data;
          end else if (up_fire) begin
            state_d = ST_FULL;
          end else if (dn_fire) begin
            main_d  = NOP_VAL;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (dn_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic ready_q;

      // Ready is registered from next state so downstream ready never reaches upstream
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          skid_q  <= NOP_VAL;
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_d != ST_FULL);
          if (ctrl_i_flush) begin
            skid_q <= NOP_VAL;
          end else if ((state_q == ST_ONE) && up_fire && !dn_fire) begin
            skid_q <= up_i_data;
          end else if ((state_q == ST_FULL) && dn_fire) begin
            skid_q <= NOP_VAL;
          end
        end
      end

      assign up_o_ready = ready_q;
    end else begin : g_noskid
      assign skid_q     = NOP_VAL;
      assign up_o_ready = ~dn_o_valid | (dn_i_ready & ~ctrl_i_stall);
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_cnt #(.W(32)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (dn_o_valid & ~dn_fire),
    .cnt (perf_o_stall_cnt)
  );

  pipe_sat_cnt #(.W(16)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl_i_flush),
    .cnt (perf_o_flush_cnt)
  );
`endif

endmodule
